// File: rtl/chunk_pingpong_scheduler_if.sv
// Loader, bank-control and compute-handshake bundle of the ping-pong chunk scheduler.
// The master side drives job control, loader beats and sub-chunk completion; the slave side is the scheduler.
interface chunk_pingpong_scheduler_if #(
  parameter int WR_DAT_CYC_NUM = 4,
  parameter int OUTPUT_BUF_NUM = 4,
  parameter int CHUNK_CNT_W    = 16
);
  localparam int WR_CNT_W = $clog2(WR_DAT_CYC_NUM);
  localparam int SEL_W    = $clog2(OUTPUT_BUF_NUM);
  localparam int SUB_W    = SEL_W + 1;

  logic                   start_i;
  logic [CHUNK_CNT_W-1:0] cfg_chunk_num_i;
  logic [SUB_W-1:0]       cfg_sub_chunk_num_i;
  logic                   ld_valid_i;
  logic                   ld_ready_o;
  logic                   chunk_wr_valid_o;
  logic [WR_CNT_W-1:0]    chunk_wr_count_o;
  logic                   chunk_wr_sel_o;
  logic                   chunk_rd_sel_o;
  logic [1:0]             ifm_chunk_rdy_o;
  logic                   run_valid_o;
  logic                   sub_chunk_start_o;
  logic                   sub_chunk_end_i;
  logic [SEL_W-1:0]       acc_buf_sel_o;
  logic                   busy_o;
  logic                   done_o;

  modport master (
    output start_i, cfg_chunk_num_i, cfg_sub_chunk_num_i, ld_valid_i, sub_chunk_end_i,
    input  ld_ready_o, chunk_wr_valid_o, chunk_wr_count_o, chunk_wr_sel_o, chunk_rd_sel_o,
           ifm_chunk_rdy_o, run_valid_o, sub_chunk_start_o, acc_buf_sel_o, busy_o, done_o
  );

  modport slave (
    input  start_i, cfg_chunk_num_i, cfg_sub_chunk_num_i, ld_valid_i, sub_chunk_end_i,
    output ld_ready_o, chunk_wr_valid_o, chunk_wr_count_o, chunk_wr_sel_o, chunk_rd_sel_o,
           ifm_chunk_rdy_o, run_valid_o, sub_chunk_start_o, acc_buf_sel_o, busy_o, done_o
  );
endinterface

// File: rtl/chunk_pingpong_scheduler.sv
// Double-buffered chunk sequencer: the loader fills the free bank while compute runs
// sub-chunks from the full one; each bank is released after its last sub-chunk.
module chunk_pingpong_scheduler #(
  parameter int WR_DAT_CYC_NUM = 4,
  parameter int OUTPUT_BUF_NUM = 4,
  parameter int CHUNK_CNT_W    = 16
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  chunk_pingpong_scheduler_if.slave     bus
);
  localparam int WR_CNT_W = $clog2(WR_DAT_CYC_NUM);
  localparam int SEL_W    = $clog2(OUTPUT_BUF_NUM);
  localparam int SUB_W    = SEL_W + 1;

  typedef enum logic [2:0] {IDLE, WAIT, START, RUN, RELEASE, DONE} state_t;

  state_t                 state;
  logic [CHUNK_CNT_W-1:0] chunk_num;
  logic [CHUNK_CNT_W-1:0] chunks_loaded;
  logic [CHUNK_CNT_W-1:0] chunks_done;
  logic [SUB_W-1:0]       sub_num;
  logic [SUB_W-1:0]       sub_num_m1;
  logic [SEL_W-1:0]       sub_idx;
  logic [SEL_W-1:0]       acc_buf_sel;
  logic [WR_CNT_W-1:0]    wr_count;
  logic                   wr_sel;
  logic                   rd_sel;
  logic [1:0]             full;
  logic                   run_valid;
  logic                   sub_chunk_start;
  logic                   done;
  logic                   busy;
  logic                   ld_ready;
  logic                   wr_fire;
  logic                   wr_last;

  // Zero sub-chunks means one; more than the accumulation buffers is clamped.
  function automatic logic [SUB_W-1:0] clamp_sub(input logic [SUB_W-1:0] n);
    if (n == '0) return SUB_W'(1);
    if (n > SUB_W'(OUTPUT_BUF_NUM)) return SUB_W'(OUTPUT_BUF_NUM);
    return n;
  endfunction

  assign busy       = (state != IDLE);
  assign ld_ready   = busy && !full[wr_sel] && (chunks_loaded < chunk_num);
  assign wr_fire    = bus.ld_valid_i && ld_ready;
  assign wr_last    = wr_fire && (wr_count == WR_CNT_W'(WR_DAT_CYC_NUM - 1));
  assign sub_num_m1 = sub_num - 1'b1;

  // NOTE: all state below is updated with nonblocking assignments so every branch
  // reads the pre-edge values, which lets the writer and RELEASE touch full[] in one cycle.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state           <= IDLE;
      chunk_num       <= '0;
      chunks_loaded   <= '0;
      chunks_done     <= '0;
      sub_num         <= '0;
      sub_idx         <= '0;
      acc_buf_sel     <= '0;
      wr_count        <= '0;
      wr_sel          <= 1'b0;
      rd_sel          <= 1'b0;
      full            <= 2'b00;
      run_valid       <= 1'b0;
      sub_chunk_start <= 1'b0;
      done            <= 1'b0;
    end else begin
      sub_chunk_start <= 1'b0;
      done            <= 1'b0;

      // Writer only ever fills the empty bank, so its set never collides with RELEASE's clear.
      if (wr_fire) begin
        if (wr_last) begin
          wr_count      <= '0;
          full[wr_sel]  <= 1'b1;
          wr_sel        <= ~wr_sel;
          chunks_loaded <= chunks_loaded + 1'b1;
        end else begin
          wr_count <= wr_count + 1'b1;
        end
      end

      unique case (state)
        IDLE: begin
          if (bus.start_i) begin
            chunk_num     <= bus.cfg_chunk_num_i;
            sub_num       <= clamp_sub(bus.cfg_sub_chunk_num_i);
            chunks_loaded <= '0;
            chunks_done   <= '0;
            sub_idx       <= '0;
            acc_buf_sel   <= '0;
            wr_count      <= '0;
            wr_sel        <= 1'b0;
            rd_sel        <= 1'b0;
            full          <= 2'b00;
            if (bus.cfg_chunk_num_i == '0) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              state <= WAIT;
            end
          end
        end
        WAIT: begin
          if (full[rd_sel]) begin
            state           <= START;
            sub_chunk_start <= 1'b1;
            run_valid       <= 1'b1;
            acc_buf_sel     <= sub_idx;
          end
        end
        START: state <= RUN;
        RUN: begin
          if (bus.sub_chunk_end_i) begin
            if (sub_idx == sub_num_m1[SEL_W-1:0]) begin
              state     <= RELEASE;
              run_valid <= 1'b0;
            end else begin
              sub_idx         <= sub_idx + 1'b1;
              acc_buf_sel     <= sub_idx + 1'b1;
              sub_chunk_start <= 1'b1;
              state           <= START;
            end
          end
        end
        RELEASE: begin
          full[rd_sel] <= 1'b0;
          rd_sel       <= ~rd_sel;
          sub_idx      <= '0;
          chunks_done  <= chunks_done + 1'b1;
          if (chunks_done == chunk_num - 1'b1) begin
            state <= DONE;
            done  <= 1'b1;
          end else begin
            state <= WAIT;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.ld_ready_o        = ld_ready;
  assign bus.chunk_wr_valid_o  = wr_fire;
  assign bus.chunk_wr_count_o  = wr_count;
  assign bus.chunk_wr_sel_o    = wr_sel;
  assign bus.chunk_rd_sel_o    = rd_sel;
  assign bus.ifm_chunk_rdy_o   = full;
  assign bus.run_valid_o       = run_valid;
  assign bus.sub_chunk_start_o = sub_chunk_start;
  assign bus.acc_buf_sel_o     = acc_buf_sel;
  assign bus.busy_o            = busy;
  assign bus.done_o            = done;
endmodule

// File: tb/tb_chunk_pingpong_scheduler.sv
// Scoreboard bench for chunk_pingpong_scheduler: stimulus queues expected write beats,
// sub-chunk launches and done pulses; a negedge monitor pops and compares them.
module tb_chunk_pingpong_scheduler;
  localparam int WR  = 4;
  localparam int OBN = 4;
  localparam int CW  = 16;

  logic clk_i = 1'b0;
  logic rst_i = 1'b0;

  chunk_pingpong_scheduler_if #(.WR_DAT_CYC_NUM(WR), .OUTPUT_BUF_NUM(OBN), .CHUNK_CNT_W(CW)) bus ();

  chunk_pingpong_scheduler #(.WR_DAT_CYC_NUM(WR), .OUTPUT_BUF_NUM(OBN), .CHUNK_CNT_W(CW)) dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .bus   (bus)
  );

  always #5 clk_i = ~clk_i;

  int checks = 0;
  int errors = 0;

  logic [2:0] exp_wr[$];   // {bank, beat index}
  logic [2:0] exp_st[$];   // {read bank, acc buffer}
  int         pending_done = 0;

  bit   auto_end  = 1'b0;
  int   end_delay = 1;
  logic resp_end  = 1'b0;
  logic man_end   = 1'b0;

  assign bus.sub_chunk_end_i = resp_end | man_end;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s: got an event, expected none", name);
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic push_wr(input logic sel);
    for (int i = 0; i < WR; i++) exp_wr.push_back({sel, 2'(i)});
  endtask

  task automatic push_st(input logic rd, input int n);
    for (int i = 0; i < n; i++) exp_st.push_back({rd, 2'(i)});
  endtask

  task automatic start_job(input int cn, input int sn);
    bus.cfg_chunk_num_i     = CW'(cn);
    bus.cfg_sub_chunk_num_i = 3'(sn);
    bus.start_i             = 1'b1;
    tick();
    bus.start_i             = 1'b0;
  endtask

  task automatic wait_done(input int budget, input string name);
    for (int n = 0; n < budget; n++) begin
      @(negedge clk_i);
      if (bus.done_o) break;
    end
    check(name, 32'(bus.done_o), 32'd1);
    tick();
  endtask

  task automatic drain(input string name);
    check({name, "_wr_left"},   32'(exp_wr.size()), 32'd0);
    check({name, "_st_left"},   32'(exp_st.size()), 32'd0);
    check({name, "_done_left"}, 32'(pending_done),  32'd0);
  endtask

  // Monitor: every DUT-presented event must match the head of its queue.
  initial begin
    forever begin
      @(negedge clk_i);
      if (rst_i) begin
        if (bus.chunk_wr_valid_o) begin
          if (exp_wr.size() == 0) fail_now("wr_beat");
          else check("wr_beat", 32'({bus.chunk_wr_sel_o, bus.chunk_wr_count_o}), 32'(exp_wr.pop_front()));
        end
        if (bus.sub_chunk_start_o) begin
          if (exp_st.size() == 0) fail_now("sub_start");
          else check("sub_start", 32'({bus.chunk_rd_sel_o, bus.acc_buf_sel_o}), 32'(exp_st.pop_front()));
          check("start_run_valid", 32'(bus.run_valid_o), 32'd1);
        end
        if (bus.done_o) begin
          if (pending_done == 0) fail_now("done_pulse");
          else pending_done--;
        end
      end
    end
  end

  // Compute-unit model: answers each launch with an end pulse end_delay cycles later.
  initial begin
    forever begin
      @(negedge clk_i);
      if (auto_end && bus.sub_chunk_start_o) begin
        repeat (end_delay) @(posedge clk_i);
        #1 resp_end = 1'b1;
        @(posedge clk_i);
        #1 resp_end = 1'b0;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    int both;
    bus.start_i             = 1'b0;
    bus.cfg_chunk_num_i     = '0;
    bus.cfg_sub_chunk_num_i = '0;
    bus.ld_valid_i          = 1'b0;

    // Reset state, with a loader beat offered while idle.
    repeat (3) @(posedge clk_i);
    #1 rst_i = 1'b1;
    bus.ld_valid_i = 1'b1;
    @(negedge clk_i);
    check("rst_busy",      32'(bus.busy_o),            32'd0);
    check("rst_ld_ready",  32'(bus.ld_ready_o),        32'd0);
    check("rst_wr_valid",  32'(bus.chunk_wr_valid_o),  32'd0);
    check("rst_run_valid", 32'(bus.run_valid_o),       32'd0);
    check("rst_start",     32'(bus.sub_chunk_start_o), 32'd0);
    check("rst_done",      32'(bus.done_o),            32'd0);
    check("rst_rdy",       32'(bus.ifm_chunk_rdy_o),   32'd0);
    check("rst_acc",       32'(bus.acc_buf_sel_o),     32'd0);
    check("rst_wr_count",  32'(bus.chunk_wr_count_o),  32'd0);
    tick();

    // Reset in the middle of RUN with both banks full: job abandoned, no done.
    auto_end = 1'b0;
    push_wr(1'b0);
    push_wr(1'b1);
    exp_st.push_back({1'b0, 2'd0});
    start_job(3, 2);
    for (int n = 0; n < 60; n++) begin
      @(negedge clk_i);
      if (bus.ifm_chunk_rdy_o == 2'b11 && bus.run_valid_o) break;
    end
    check("mid_full_run", 32'({bus.ifm_chunk_rdy_o, bus.run_valid_o}), 32'b111);
    tick();
    rst_i = 1'b0;
    #1;
    check("mid_rst_rdy",       32'(bus.ifm_chunk_rdy_o),  32'd0);
    check("mid_rst_run_valid", 32'(bus.run_valid_o),      32'd0);
    check("mid_rst_busy",      32'(bus.busy_o),           32'd0);
    check("mid_rst_ld_ready",  32'(bus.ld_ready_o),       32'd0);
    bus.ld_valid_i = 1'b0;
    repeat (2) tick();
    rst_i = 1'b1;
    repeat (3) tick();
    check("mid_rst_idle", 32'(bus.busy_o), 32'd0);
    drain("mid_rst");

    // One chunk, one sub-chunk, back-to-back beats.
    auto_end  = 1'b1;
    end_delay = 1;
    push_wr(1'b0);
    exp_st.push_back({1'b0, 2'd0});
    pending_done++;
    bus.ld_valid_i = 1'b1;
    start_job(1, 1);
    for (int n = 0; n < 20; n++) begin
      @(negedge clk_i);
      if (bus.ifm_chunk_rdy_o != 2'b00) break;
    end
    check("t1_full", 32'(bus.ifm_chunk_rdy_o), 32'b01);
    wait_done(30, "t1_done");
    check("t1_released", 32'(bus.ifm_chunk_rdy_o), 32'd0);
    check("t1_idle",     32'(bus.busy_o),          32'd0);
    bus.ld_valid_i = 1'b0;
    drain("t1");

    // Three chunks of four sub-chunks, loader always valid.
    end_delay = 3;
    push_wr(1'b0);
    push_wr(1'b1);
    push_wr(1'b0);
    push_st(1'b0, 4);
    push_st(1'b1, 4);
    push_st(1'b0, 4);
    pending_done++;
    bus.ld_valid_i = 1'b1;
    start_job(3, 4);
    both = 0;
    for (int n = 0; n < 400; n++) begin
      @(negedge clk_i);
      if (bus.ifm_chunk_rdy_o == 2'b11) begin
        both++;
        check("t2_ready_when_full", 32'(bus.ld_ready_o), 32'd0);
      end
      if (bus.done_o) break;
    end
    check("t2_done",       32'(bus.done_o), 32'd1);
    check("t2_stall_seen", 32'(both > 0),   32'd1);
    tick();
    bus.ld_valid_i = 1'b0;
    drain("t2");

    // Loader stall mid-chunk, with a spurious end pulse and a start while busy.
    end_delay = 1;
    push_wr(1'b0);
    push_st(1'b0, 2);
    pending_done++;
    bus.ld_valid_i = 1'b1;
    start_job(1, 2);
    tick();
    tick();
    bus.ld_valid_i      = 1'b0;
    man_end             = 1'b1;
    bus.cfg_chunk_num_i = '0;
    bus.start_i         = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk_i);
      check("t3_hold_run", 32'(bus.run_valid_o), 32'd0);
      tick();
      if (i == 0) begin
        man_end     = 1'b0;
        bus.start_i = 1'b0;
      end
    end
    bus.ld_valid_i = 1'b1;
    tick();
    tick();
    bus.ld_valid_i = 1'b0;
    @(negedge clk_i);
    check("t3_full_set",  32'(bus.ifm_chunk_rdy_o),   32'b01);
    check("t3_no_start",  32'(bus.sub_chunk_start_o), 32'd0);
    @(negedge clk_i);
    check("t3_start_next", 32'(bus.sub_chunk_start_o), 32'd1);
    tick();
    wait_done(40, "t3_done");
    drain("t3");

    // Last beat into bank 1 lands in the same cycle as RELEASE of bank 0.
    auto_end = 1'b0;
    push_wr(1'b0);
    push_wr(1'b1);
    exp_st.push_back({1'b0, 2'd0});
    exp_st.push_back({1'b1, 2'd0});
    pending_done++;
    bus.ld_valid_i = 1'b1;
    start_job(2, 1);
    repeat (7) tick();
    bus.ld_valid_i = 1'b0;
    man_end        = 1'b1;
    tick();
    man_end        = 1'b0;
    bus.ld_valid_i = 1'b1;
    @(negedge clk_i);
    check("t4_before", 32'(bus.ifm_chunk_rdy_o), 32'b01);
    tick();
    bus.ld_valid_i = 1'b0;
    @(negedge clk_i);
    check("t4_swap", 32'(bus.ifm_chunk_rdy_o), 32'b10);
    for (int n = 0; n < 20; n++) begin
      @(negedge clk_i);
      if (bus.run_valid_o && !bus.sub_chunk_start_o) break;
    end
    check("t4_run", 32'(bus.run_valid_o), 32'd1);
    tick();
    man_end = 1'b1;
    tick();
    man_end = 1'b0;
    wait_done(10, "t4_done");
    drain("t4");

    // Zero-chunk job completes without any write or compute.
    pending_done++;
    bus.ld_valid_i = 1'b1;
    start_job(0, 1);
    for (int n = 0; n < 2; n++) begin
      @(negedge clk_i);
      if (bus.done_o) break;
    end
    check("t5_done", 32'(bus.done_o), 32'd1);
    tick();
    check("t5_idle", 32'(bus.busy_o), 32'd0);
    bus.ld_valid_i = 1'b0;
    repeat (2) tick();
    drain("t5");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
